// File: rtl/microwave_power_ctrl_if.sv
// Panel/timer-side signal bundle for the microwave cook sequencer.
// The master modport is the panel/timer side; the slave modport is the controller.
interface microwave_power_ctrl_if;
  logic [9:0] keypad;
  logic       pwr_setn;
  logic       startn;
  logic       stopn;
  logic       door_closed;
  logic       timer_zero;
  logic       tick_1hz;
  logic       timer_clr;
  logic       mag_on;
  logic       beep;
  logic [3:0] power_level;
  logic [2:0] state;

  modport master (
    output keypad, pwr_setn, startn, stopn, door_closed, timer_zero,
    input  tick_1hz, timer_clr, mag_on, beep, power_level, state
  );

  modport slave (
    input  keypad, pwr_setn, startn, stopn, door_closed, timer_zero,
    output tick_1hz, timer_clr, mag_on, beep, power_level, state
  );
endinterface

// File: rtl/microwave_power_ctrl.sv
// Cook sequencer: IDLE/SET_PWR/COOK/PAUSE/DONE FSM, 1 Hz tick, magnetron duty window, door interlock.
// Define DEBOUNCE_EN to add a DB_CYCLES stable-level filter behind the button synchronizers.
module microwave_power_ctrl #(
  parameter int CLK_HZ   = 100,
  parameter int WINDOW_S = 10,
`ifdef DEBOUNCE_EN
  parameter int DB_CYCLES = 4,
`endif
  parameter int BEEP_S   = 3
) (
  input logic                   clk,
  input logic                   clearn,
  microwave_power_ctrl_if.slave bus
);
  typedef enum logic [2:0] {
    IDLE = 3'd0, SET_PWR = 3'd1, COOK = 3'd2, PAUSE = 3'd3, DONE = 3'd4
  } state_e;

  localparam int PW       = $clog2(CLK_HZ);
  localparam int WW       = $clog2(WINDOW_S);
  localparam int BEEP_CYC = BEEP_S * CLK_HZ;
  localparam int BW       = $clog2(BEEP_CYC);
  localparam logic [PW-1:0] PRE_MAX  = PW'(CLK_HZ - 1);
  localparam logic [WW-1:0] WIN_MAX  = WW'(WINDOW_S - 1);
  localparam logic [BW-1:0] BEEP_MAX = BW'(BEEP_CYC - 1);

  // Button order in every vector below: {stop, start, pwr_set}
  logic [2:0] s1_q, s2_q;
  logic [2:0] press;

  always_ff @(posedge clk or negedge clearn) begin
    if (!clearn) begin
      s1_q <= 3'b111;
      s2_q <= 3'b111;
    end else begin
      s1_q <= {bus.stopn, bus.startn, bus.pwr_setn};
      s2_q <= s1_q;
    end
  end

`ifdef DEBOUNCE_EN
  localparam int DW = $clog2(DB_CYCLES);
  logic [2:0]         filt_q, filt_d;
  logic [2:0][DW-1:0] db_cnt_q, db_cnt_d;

  // The press fires on the same cycle the filtered level is accepted, so it acts 2+DB_CYCLES after the pin.
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      filt_d[i]   = filt_q[i];
      db_cnt_d[i] = '0;
      press[i]    = 1'b0;
      if (s2_q[i] != filt_q[i]) begin
        if (db_cnt_q[i] == DW'(DB_CYCLES - 1)) begin
          filt_d[i] = s2_q[i];
          press[i]  = filt_q[i];
        end else begin
          db_cnt_d[i] = db_cnt_q[i] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge clearn) begin
    if (!clearn) begin
      filt_q   <= 3'b111;
      db_cnt_q <= '0;
    end else begin
      filt_q   <= filt_d;
      db_cnt_q <= db_cnt_d;
    end
  end
`else
  logic [2:0] s3_q;

  always_ff @(posedge clk or negedge clearn) begin
    if (!clearn) s3_q <= 3'b111;
    else         s3_q <= s2_q;
  end

  assign press = s3_q & ~s2_q;
`endif

  logic p_stop, p_start, p_pwr;
  assign p_stop  = press[2];
  assign p_start = press[1];
  assign p_pwr   = press[0];

  logic       key_one;
  logic [3:0] key_digit;

  always_comb begin
    key_one   = (bus.keypad != 10'd0) && ((bus.keypad & (bus.keypad - 10'd1)) == 10'd0);
    key_digit = 4'd10;
    for (int i = 1; i < 10; i++) begin
      if (bus.keypad[i]) key_digit = 4'(i);
    end
  end

  state_e        state_q, state_d;
  logic [3:0]    pwr_q, pwr_d;
  logic [PW-1:0] pre_q, pre_d;
  logic [WW-1:0] win_q, win_d;
  logic [BW-1:0] beep_cnt_q, beep_cnt_d;
  logic          mag_q, mag_d;
  logic          tick_q, tick_d;
  logic          clr_q, clr_d;

  always_comb begin
    state_d    = state_q;
    pwr_d      = pwr_q;
    pre_d      = pre_q;
    win_d      = win_q;
    beep_cnt_d = '0;
    tick_d     = 1'b0;
    clr_d      = 1'b0;
    mag_d      = (32'(win_q) * 32'd10) < (32'(pwr_q) * 32'(WINDOW_S));
    case (state_q)
      IDLE: begin
        if (p_stop) begin
          clr_d = 1'b1;
        end else if (p_start) begin
          if (bus.door_closed && !bus.timer_zero) begin
            state_d = COOK;
            pre_d   = '0;
            win_d   = '0;
          end
        end else if (p_pwr) begin
          state_d = SET_PWR;
        end
      end
      SET_PWR: begin
        if (p_stop) begin
          state_d = IDLE;
        end else if (key_one) begin
          pwr_d   = key_digit;
          state_d = IDLE;
        end
      end
      COOK: begin
        // Leaving COOK freezes the prescaler, so a pause never produces a partial-second tick.
        if (p_stop || !bus.door_closed) begin
          state_d = PAUSE;
        end else if (bus.timer_zero) begin
          state_d = DONE;
          pre_d   = '0;
          win_d   = '0;
        end else if (pre_q == PRE_MAX) begin
          pre_d  = '0;
          tick_d = 1'b1;
          win_d  = (win_q == WIN_MAX) ? '0 : win_q + 1'b1;
        end else begin
          pre_d = pre_q + 1'b1;
        end
      end
      PAUSE: begin
        if (p_stop) begin
          clr_d   = 1'b1;
          state_d = IDLE;
          pre_d   = '0;
          win_d   = '0;
        end else if (p_start && bus.door_closed) begin
          state_d = COOK;
        end
      end
      DONE: begin
        if (p_start || p_stop || beep_cnt_q == BEEP_MAX) begin
          state_d = IDLE;
        end else begin
          beep_cnt_d = beep_cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge clearn) begin
    if (!clearn) begin
      state_q    <= IDLE;
      pwr_q      <= 4'd10;
      pre_q      <= '0;
      win_q      <= '0;
      beep_cnt_q <= '0;
      mag_q      <= 1'b0;
      tick_q     <= 1'b0;
      clr_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      pwr_q      <= pwr_d;
      pre_q      <= pre_d;
      win_q      <= win_d;
      beep_cnt_q <= beep_cnt_d;
      mag_q      <= mag_d;
      tick_q     <= tick_d;
      clr_q      <= clr_d;
    end
  end

  // Door gating is combinational so the magnetron drops in the same cycle the door opens.
  assign bus.mag_on      = mag_q & bus.door_closed & (state_q == COOK);
  assign bus.beep        = (state_q == DONE);
  assign bus.tick_1hz    = tick_q;
  assign bus.timer_clr   = clr_q;
  assign bus.power_level = pwr_q;
  assign bus.state       = state_q;
endmodule

// File: tb/tb_microwave_power_ctrl.sv
// Directed-plus-random bench for microwave_power_ctrl with a seconds/duty-window reference model.
module tb_microwave_power_ctrl;
  localparam int CLK_HZ   = 100;
  localparam int WINDOW_S = 10;
  localparam int BEEP_S   = 3;

  logic clk = 1'b0;
  logic clearn;
  always #5 clk = ~clk;

  microwave_power_ctrl_if bus ();
  microwave_power_ctrl dut (.clk(clk), .clearn(clearn), .bus(bus));

  int checks = 0;
  int errors = 0;
  int tick_cnt = 0, clr_cnt = 0, cook_run = 0, last_int = 0;
  int d, a, b, exp_pwr, sec, pause_sec, n, t0, c0;
  bit paused;

  // Tick spacing is measured in cycles actually spent in COOK.
  always @(negedge clk) begin
    if (bus.tick_1hz === 1'b1) begin
      last_int <= cook_run + 1;
      cook_run <= 0;
      tick_cnt <= tick_cnt + 1;
    end else if (bus.state === 3'd2) begin
      cook_run <= cook_run + 1;
    end
    if (bus.timer_clr === 1'b1) clr_cnt <= clr_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic press(input logic p, input logic s, input logic t);
    @(negedge clk);
    bus.pwr_setn = ~p;
    bus.startn   = ~s;
    bus.stopn    = ~t;
    repeat (4) @(negedge clk);
    bus.pwr_setn = 1'b1;
    bus.startn   = 1'b1;
    bus.stopn    = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic wait_tick(input int budget);
    int base;
    int k;
    base = tick_cnt;
    k = 0;
    while (tick_cnt == base && k < budget) begin
      @(negedge clk);
      k++;
    end
    check("tick_arrives", 32'(tick_cnt != base), 1);
  endtask

  initial begin
    bus.keypad      = '0;
    bus.pwr_setn    = 1'b1;
    bus.startn      = 1'b1;
    bus.stopn       = 1'b1;
    bus.door_closed = 1'b1;
    bus.timer_zero  = 1'b0;
    clearn          = 1'b0;
    repeat (10) @(negedge clk);
    check("rst_state", bus.state, 0);
    check("rst_power", bus.power_level, 10);
    check("rst_mag", bus.mag_on, 0);
    check("rst_tick", bus.tick_1hz, 0);
    check("rst_beep", bus.beep, 0);
    check("rst_clr", bus.timer_clr, 0);
    clearn = 1'b1;

    press(1, 0, 0);
    check("setpwr_enter", bus.state, 1);
    press(0, 0, 1);
    check("setpwr_cancel_state", bus.state, 0);
    check("setpwr_cancel_power", bus.power_level, 10);

    bus.door_closed = 1'b0;
    t0 = tick_cnt;
    press(0, 1, 0);
    repeat (200) @(negedge clk);
    check("door_open_start_state", bus.state, 0);
    check("door_open_start_mag", bus.mag_on, 0);
    check("door_open_start_tick", tick_cnt - t0, 0);
    bus.door_closed = 1'b1;

    bus.timer_zero = 1'b1;
    press(0, 1, 0);
    check("tz_start_ignored", bus.state, 0);
    bus.timer_zero = 1'b0;

    c0 = clr_cnt;
    press(0, 0, 1);
    check("idle_stop_clr", clr_cnt - c0, 1);
    check("idle_stop_state", bus.state, 0);

    for (int it = 0; it < 4; it++) begin
      d = $urandom_range(0, 9);
      exp_pwr = (d == 0) ? 10 : d;
      press(1, 0, 0);
      check("pwr_enter", bus.state, 1);
      a = $urandom_range(0, 9);
      b = (a + 1 + $urandom_range(0, 8)) % 10;
      bus.keypad = (10'd1 << a) | (10'd1 << b);
      repeat (3) @(negedge clk);
      check("multi_key_wait", bus.state, 1);
      bus.keypad = '0;
      repeat (2) @(negedge clk);
      check("no_key_wait", bus.state, 1);
      bus.keypad = 10'd1 << d;
      @(negedge clk);
      bus.keypad = '0;
      check("key_state", bus.state, 0);
      check("key_power", bus.power_level, exp_pwr);

      press(0, 1, 0);
      check("cook_enter", bus.state, 2);
      check("mag_sec0", bus.mag_on, 32'(0 < exp_pwr * WINDOW_S));
      pause_sec = $urandom_range(1, 8);
      wait_tick(2 * CLK_HZ);
      for (int s = 1; s <= WINDOW_S + 1; s++) begin
        sec = s % WINDOW_S;
        paused = 1'b0;
        repeat ($urandom_range(20, 60)) @(negedge clk);
        check("mag_sec", bus.mag_on, 32'(sec * 10 < exp_pwr * WINDOW_S));
        if (s == pause_sec) begin
          bus.door_closed = 1'b0;
          #1;
          check("door_mag_drop", bus.mag_on, 0);
          @(negedge clk);
          check("door_pause", bus.state, 3);
          t0 = tick_cnt;
          repeat (250) @(negedge clk);
          check("pause_no_tick", tick_cnt - t0, 0);
          bus.door_closed = 1'b1;
          repeat (20) @(negedge clk);
          check("close_no_resume", bus.state, 3);
          press(0, 1, 0);
          check("resume", bus.state, 2);
          paused = 1'b1;
        end
        wait_tick(6 * CLK_HZ);
        check("tick_period", last_int, paused ? CLK_HZ + 1 : CLK_HZ);
      end

      repeat (30) @(negedge clk);
      case (it % 4)
        0: begin
          bus.timer_zero = 1'b1;
          @(negedge clk);
          bus.timer_zero = 1'b0;
          check("done_state", bus.state, 4);
          check("done_mag", bus.mag_on, 0);
          check("done_beep", bus.beep, 1);
          n = 0;
          while (bus.beep === 1'b1 && n < 2 * BEEP_S * CLK_HZ) begin
            n++;
            @(negedge clk);
          end
          check("beep_len", n, BEEP_S * CLK_HZ);
          check("done_to_idle", bus.state, 0);
        end
        1: begin
          c0 = clr_cnt;
          press(0, 0, 1);
          check("stop1_pause", bus.state, 3);
          press(0, 0, 1);
          check("stop2_idle", bus.state, 0);
          check("stop_stop_clr", clr_cnt - c0, 1);
        end
        2: begin
          press(0, 0, 1);
          check("stop_pause", bus.state, 3);
          press(0, 1, 1);
          check("start_stop_idle", bus.state, 0);
        end
        default: begin
          bus.timer_zero = 1'b1;
          @(negedge clk);
          bus.timer_zero = 1'b0;
          check("done2_state", bus.state, 4);
          repeat (50) @(negedge clk);
          press(0, 1, 0);
          check("done_early_state", bus.state, 0);
          check("done_early_beep", bus.beep, 0);
        end
      endcase
    end

    press(1, 0, 0);
    bus.keypad = 10'd1 << 7;
    @(negedge clk);
    bus.keypad = '0;
    press(0, 1, 0);
    repeat (30) @(negedge clk);
    check("pre_reset_mag", bus.mag_on, 1);
    clearn = 1'b0;
    #1;
    check("async_rst_mag", bus.mag_on, 0);
    check("async_rst_state", bus.state, 0);
    check("async_rst_power", bus.power_level, 10);
    repeat (3) @(negedge clk);
    clearn = 1'b1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
